input_port_receiver: RTL and testbench
======================================

// Module: input_port_receiver
// PURPOSE
// - Receive end of the leaf packet interface: accepts packets the network delivers to one input port,
//   buffers payloads in a circular BRAM FIFO, presents them to user logic with a valid/ack handshake.
// - Returns freespace credits to the upstream output port as credit packets, one per FREESPACE_UPDATE_SIZE payloads consumed.
// PARAMETERS
// - PACKET_BITS 97: packet width. Layout, MSB down: [PACKET_BITS-1] vld, dst_leaf, dst_port, fifo_addr, ...; payload in [PAYLOAD_BITS-1:0]; other bits ignored.
// - NUM_LEAF_BITS 6: leaf id width.
// - NUM_PORT_BITS 4: port id width.
// - NUM_ADDR_BITS 7: fifo_addr field width.
// - PAYLOAD_BITS 64: user payload width.
// - NUM_BRAM_ADDR_BITS 7: FIFO depth = 2**NUM_BRAM_ADDR_BITS.
// - FREESPACE_UPDATE_SIZE 64: payloads consumed per credit packet; must be <= FIFO depth.
// PORTS
// - clk  in  1  clock.
// - reset  in  1  synchronous, active-low reset.
// - update_src_en  in  1  load src_leaf/src_port/src_fifo_addr (1-cycle pulse).
// - src_leaf  in  NUM_LEAF_BITS  leaf id of upstream sender (credit destination).
// - src_port  in  NUM_PORT_BITS  port id of upstream sender.
// - src_fifo_addr  in  NUM_ADDR_BITS  fifo_addr placed in credit packets.
// - internal_in  in  PACKET_BITS  packet from leaf interface; valid when its vld bit is 1.
// - dout_leaf_interface2user  out  PAYLOAD_BITS  head payload.
// - vld_interface2user  out  1  head payload valid.
// - ack_user2interface  in  1  user pops head when vld & ack.
// - credit_out  out  PACKET_BITS  credit packet to upstream.
// - credit_empty  out  1  no credit packet pending.
// - credit_rd_en  in  1  network takes credit_out when !credit_empty & rd_en.
// - overflow  out  1  sticky overflow flag (see CONFIGURATION).
// BEHAVIOUR
// - Reset (reset==0 at posedge): wr/rd pointers, occupancy, consumed count, pending credits, src regs, overflow -> 0;
//   vld_interface2user=0, credit_empty=1, dout/credit_out=0. Reset mid-transfer discards FIFO contents and pending credits.
// - Write: internal_in vld=1 and FIFO not full -> payload written at wr_ptr, wr_ptr+1 mod depth. No backpressure on network.
// - Read: registered BRAM read into output register (FWFT). Into empty FIFO: packet at edge N -> vld_interface2user=1 after edge N+2.
// - Handshake: dout stable while vld=1 & ack=0. vld&ack pops; next entry valid next cycle if occupancy allows
//   (back-to-back one pop per cycle). ack with vld=0 ignored.
// - Simultaneous write and pop: occupancy unchanged; full/empty computed from occupancy counter (NUM_BRAM_ADDR_BITS+1 bits).
// - Full: occupancy == depth; arriving packet dropped (see CONFIGURATION). Pointers wrap depth-1 -> 0.
// - Credit: consumed counter increments per pop; on reaching FREESPACE_UPDATE_SIZE resets to 0 and pending += 1.
//   pending is 4 bits, saturates at 15. credit_empty = (pending==0).
// - credit_out = {1'b1, src_leaf, src_port, src_fifo_addr, zero fill, payload=FREESPACE_UPDATE_SIZE}, combinational from src regs.
// - credit_rd_en & !credit_empty -> pending -= 1; increment and take in the same cycle -> pending unchanged.
// - update_src_en: new src values used by credits from next cycle; FIFO and counters unaffected.
// CONFIGURATION
// - INPUT_PORT_OVERFLOW_CHECK_EN defined: write while full drops the packet and sets overflow sticky until reset.
// - Not defined: write while full silently dropped; overflow tied 0; no flag logic.
// TESTING
// - Reset: drive reset=0 2 cycles -> vld_interface2user=0, credit_empty=1, overflow=0.
// - Single packet payload 64'hDEAD_BEEF at cycle 0, ack=1 -> vld=1 with dout=64'hDEAD_BEEF at cycle 2, vld=0 at cycle 3.
// - 10 back-to-back packets, ack held low 5 cycles then 1 -> payloads out in order, one per cycle, no loss.
// - FREESPACE_UPDATE_SIZE=4, src_leaf=6'd3, src_port=4'd2, 8 pops, credit_rd_en=0 -> pending=2;
//   credit_out payload=4, leaf 3, port 2; two rd_en pulses -> credit_empty=1.
// - Fill 128 entries, send 129th with macro -> packet dropped, overflow=1, drain returns first 128 payloads exactly.
// - Pop and write in same cycle at occupancy 127, plus reset asserted mid-drain -> occupancy stays 127; after reset all outputs at reset values.

Source files
------------

// File: rtl/input_port_receiver.sv
// -----------------------------------------------------------------------------
// input_port_receiver
//
// Receive end of the leaf packet interface. Packets addressed to this input
// port are buffered in a circular BRAM FIFO. Their payloads are presented to
// user logic first-word-fall-through through a registered BRAM read and an
// output register. Every FREESPACE_UPDATE_SIZE payloads the user consumes, one
// freespace credit is queued for the upstream output port.
//
// Optional feature macro: INPUT_PORT_OVERFLOW_CHECK_EN
//   defined   : a packet arriving while the FIFO is full is dropped and
//               `overflow` is set. It stays set until reset.
//   undefined : a packet arriving while the FIFO is full is dropped silently
//               and `overflow` is tied low.
//
// Ports
//   clk                       in   clock
//   reset                     in   synchronous, active-low reset
//   update_src_en             in   load src_leaf/src_port/src_fifo_addr
//   src_leaf                  in   leaf id of the upstream sender
//   src_port                  in   port id of the upstream sender
//   src_fifo_addr             in   fifo_addr field placed in credit packets
//   internal_in               in   packet from the network (MSB = vld)
//   dout_leaf_interface2user  out  head payload
//   vld_interface2user        out  head payload valid
//   ack_user2interface        in   pops the head when vld & ack
//   credit_out                out  credit packet to upstream
//   credit_empty              out  no credit packet pending
//   credit_rd_en              in   network takes credit_out when !credit_empty
//   overflow                  out  sticky drop flag (see macro above)
// -----------------------------------------------------------------------------
module input_port_receiver #(
   parameter int PACKET_BITS           = 97,
   parameter int NUM_LEAF_BITS         = 6,
   parameter int NUM_PORT_BITS         = 4,
   parameter int NUM_ADDR_BITS         = 7,
   parameter int PAYLOAD_BITS          = 64,
   parameter int NUM_BRAM_ADDR_BITS    = 7,
   parameter int FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     update_src_en,
   input  logic [NUM_LEAF_BITS-1:0] src_leaf,
   input  logic [NUM_PORT_BITS-1:0] src_port,
   input  logic [NUM_ADDR_BITS-1:0] src_fifo_addr,
   input  logic [PACKET_BITS-1:0]   internal_in,
   output logic [PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
   output logic                     vld_interface2user,
   input  logic                     ack_user2interface,
   output logic [PACKET_BITS-1:0]   credit_out,
   output logic                     credit_empty,
   input  logic                     credit_rd_en,
   output logic                     overflow
);

   localparam int AW    = NUM_BRAM_ADDR_BITS;
   localparam int DEPTH = 1 << AW;
   localparam int CW    = AW + 1;  // holds 0..DEPTH
   localparam int LEAF_HI = PACKET_BITS - 2;
   localparam int PORT_HI = LEAF_HI - NUM_LEAF_BITS;
   localparam int ADDR_HI = PORT_HI - NUM_PORT_BITS;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [PAYLOAD_BITS-1:0]  mem [DEPTH];
   logic [PAYLOAD_BITS-1:0]  rdata_q;                 // BRAM read register
   logic                     s1_vld_q,  s1_vld_d;     // rdata_q holds an entry
   logic [PAYLOAD_BITS-1:0]  dout_q,    dout_d;
   logic                     vld_q,     vld_d;
   logic [AW-1:0]            wr_ptr_q,  wr_ptr_d;
   logic [AW-1:0]            rd_ptr_q,  rd_ptr_d;     // next BRAM entry to fetch
   logic [CW-1:0]            count_q,   count_d;      // written and not yet popped
   logic [CW-1:0]            ucnt_q,    ucnt_d;       // written and not yet fetched
   logic [CW-1:0]            consumed_q, consumed_d;
   logic [3:0]               pending_q, pending_d;
   logic [NUM_LEAF_BITS-1:0] src_leaf_q, src_leaf_d;
   logic [NUM_PORT_BITS-1:0] src_port_q, src_port_d;
   logic [NUM_ADDR_BITS-1:0] src_addr_q, src_addr_d;

   logic in_vld, full, wr_en, pop, s2_load, fetch, credit_inc, credit_take;

   // Header fields of arriving packets are not needed on the receive side.
   logic unused_hdr;
   assign unused_hdr = ^internal_in[PACKET_BITS-2:PAYLOAD_BITS];

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default value first. This keeps the
   // block purely combinational, so no latch can be inferred.
   always_comb begin
      in_vld      = internal_in[PACKET_BITS-1];
      full        = (count_q == CW'(DEPTH));
      wr_en       = in_vld & ~full;
      pop         = vld_q & ack_user2interface;
      // The output register refills whenever it is empty or being popped.
      s2_load     = s1_vld_q & (~vld_q | pop);
      // The read register refills whenever it is empty or draining into dout.
      fetch       = (ucnt_q != '0) & (~s1_vld_q | s2_load);
      credit_inc  = pop & (consumed_q == CW'(FREESPACE_UPDATE_SIZE - 1));
      credit_take = credit_rd_en & (pending_q != 4'd0);

      count_d    = count_q + CW'(wr_en) - CW'(pop);
      ucnt_d     = ucnt_q + CW'(wr_en) - CW'(fetch);
      wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = fetch ? rd_ptr_q + AW'(1) : rd_ptr_q;
      s1_vld_d   = fetch | (s1_vld_q & ~s2_load);
      vld_d      = s2_load | (vld_q & ~pop);
      dout_d     = s2_load ? rdata_q : dout_q;

      consumed_d = consumed_q;
      if (pop) consumed_d = credit_inc ? '0 : consumed_q + CW'(1);

      pending_d = pending_q;
      unique case ({credit_inc, credit_take})
         2'b10:   pending_d = (pending_q == 4'd15) ? 4'd15 : pending_q + 4'd1;
         2'b01:   pending_d = pending_q - 4'd1;
         default: pending_d = pending_q;   // idle, or increment and take cancel
      endcase

      src_leaf_d = update_src_en ? src_leaf      : src_leaf_q;
      src_port_d = update_src_en ? src_port      : src_port_q;
      src_addr_d = update_src_en ? src_fifo_addr : src_addr_q;
   end

   // ---------------------------------------------------------------------------
   // Control and output registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. Every register
   // therefore samples values from before the edge, whatever the statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_vld_q   <= 1'b0;
         dout_q     <= '0;
         vld_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ucnt_q     <= '0;
         consumed_q <= '0;
         pending_q  <= '0;
         src_leaf_q <= '0;
         src_port_q <= '0;
         src_addr_q <= '0;
      end else begin
         s1_vld_q   <= s1_vld_d;
         dout_q     <= dout_d;
         vld_q      <= vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ucnt_q     <= ucnt_d;
         consumed_q <= consumed_d;
         pending_q  <= pending_d;
         src_leaf_q <= src_leaf_d;
         src_port_q <= src_port_d;
         src_addr_q <= src_addr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // BRAM with registered read
   // ---------------------------------------------------------------------------
   // NOTE: the array and its read register are deliberately left without reset,
   // so they map onto block RAM. Stale contents are never visible, because
   // s1_vld_q and vld_q are reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= internal_in[PAYLOAD_BITS-1:0];
      // A fetch only targets entries written at an earlier edge, so it never
      // collides with the write address.
      if (fetch) rdata_q <= mem[rd_ptr_q];
   end

   // ---------------------------------------------------------------------------
   // Credit packet: driven from the source registers while a credit is pending,
   // all zero otherwise.
   // ---------------------------------------------------------------------------
   always_comb begin
      credit_out = '0;
      if (pending_q != 4'd0) begin
         credit_out[PACKET_BITS-1]                 = 1'b1;
         credit_out[LEAF_HI -: NUM_LEAF_BITS]      = src_leaf_q;
         credit_out[PORT_HI -: NUM_PORT_BITS]      = src_port_q;
         credit_out[ADDR_HI -: NUM_ADDR_BITS]      = src_addr_q;
         credit_out[PAYLOAD_BITS-1:0]              = PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE);
      end
   end

   assign credit_empty             = (pending_q == 4'd0);
   assign dout_leaf_interface2user = dout_q;
   assign vld_interface2user       = vld_q;

   // ---------------------------------------------------------------------------
   // Optional overflow flag
   // ---------------------------------------------------------------------------
`ifdef INPUT_PORT_OVERFLOW_CHECK_EN
   logic overflow_q, overflow_d;

   assign overflow_d = overflow_q | (in_vld & full);

   always_ff @(posedge clk) begin
      if (!reset) overflow_q <= 1'b0;
      else        overflow_q <= overflow_d;
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_receiver.sv
// -----------------------------------------------------------------------------
// tb_input_port_receiver
//
// Self-checking bench for input_port_receiver, built with a credit granularity
// of 4. The reference model keeps every accepted payload in a queue, tagged with
// the edge at which it was written. A payload becomes visible to the user two
// edges after it is written, or at the edge that pops its predecessor, whichever
// comes later. Credits are tracked as plain integers.
// -----------------------------------------------------------------------------
module tb_input_port_receiver;

   localparam int PKT   = 97;
   localparam int FUS   = 4;
   localparam int DEPTH = 128;

   logic            clk = 1'b0;
   logic            reset;
   logic            update_src_en;
   logic [5:0]      src_leaf;
   logic [3:0]      src_port;
   logic [6:0]      src_fifo_addr;
   logic [PKT-1:0]  internal_in;
   logic [63:0]     dout;
   logic            vld;
   logic            ack;
   logic [PKT-1:0]  credit_out;
   logic            credit_empty;
   logic            credit_rd_en;
   logic            overflow;

   always #5 clk = ~clk;

   input_port_receiver #(
      .PACKET_BITS(97), .NUM_LEAF_BITS(6), .NUM_PORT_BITS(4), .NUM_ADDR_BITS(7),
      .PAYLOAD_BITS(64), .NUM_BRAM_ADDR_BITS(7), .FREESPACE_UPDATE_SIZE(FUS)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .update_src_en            (update_src_en),
      .src_leaf                 (src_leaf),
      .src_port                 (src_port),
      .src_fifo_addr            (src_fifo_addr),
      .internal_in              (internal_in),
      .dout_leaf_interface2user (dout),
      .vld_interface2user       (vld),
      .ack_user2interface       (ack),
      .credit_out               (credit_out),
      .credit_empty             (credit_empty),
      .credit_rd_en             (credit_rd_en),
      .overflow                 (overflow)
   );

   // ---------------------------------------------------------------- model ----
   typedef struct { logic [63:0] payload; int w; } entry_t;
   entry_t      mq[$];
   int          cyc, last_pop, m_pending, m_consumed;
   bit          m_ovf;
   logic [5:0]  m_leaf;
   logic [3:0]  m_port;
   logic [6:0]  m_faddr;

   logic [63:0] got[$];        // payloads the DUT handed over
   int          pop_steps[$];  // edges at which those handovers happened
   logic [63:0] exp_list[$];
   int          n_checks, n_pass;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("%0t FAIL %s: got %0h expected %0h", $time, name, act, exp);
   endtask

   function automatic bit m_vis();
      int t;
      if (mq.size() == 0) return 1'b0;
      t = (mq[0].w + 2 > last_pop) ? mq[0].w + 2 : last_pop;
      return t <= cyc;
   endfunction

   function automatic logic [PKT-1:0] m_credit();
      logic [PKT-1:0] c = '0;
      if (m_pending > 0) c = {1'b1, m_leaf, m_port, m_faddr, 15'd0, 64'(FUS)};
      return c;
   endfunction

   function automatic int mism();
      int n = 0;
      for (int i = 0; i < exp_list.size() && i < got.size(); i++)
         if (got[i] !== exp_list[i]) n++;
      return n;
   endfunction

   task automatic drive(input bit v, input logic [63:0] pl);
      internal_in = {v, 32'($urandom), pl};
   endtask

   // Advance the model past the coming edge, run the edge, then compare.
   task automatic step();
      bit pop, take, inc, acc, drop;
      if (!reset) begin
         mq.delete();
         m_pending = 0; m_consumed = 0; m_ovf = 0;
         m_leaf = '0; m_port = '0; m_faddr = '0;
         last_pop = -1000;
      end else begin
         pop  = m_vis() && ack;
         take = (m_pending > 0) && credit_rd_en;
         acc  = internal_in[PKT-1] && (mq.size() < DEPTH);
         drop = internal_in[PKT-1] && !acc;
         inc  = 1'b0;
         if (pop) begin
            void'(mq.pop_front());
            last_pop = cyc + 1;
            m_consumed++;
            if (m_consumed == FUS) begin m_consumed = 0; inc = 1'b1; end
         end
         if (inc && !take)      m_pending = (m_pending == 15) ? 15 : m_pending + 1;
         else if (take && !inc) m_pending--;
         if (acc)  mq.push_back('{internal_in[63:0], cyc + 1});
         if (drop) m_ovf = 1'b1;
         if (update_src_en) begin m_leaf = src_leaf; m_port = src_port; m_faddr = src_fifo_addr; end
         if (vld && ack) begin got.push_back(dout); pop_steps.push_back(cyc + 1); end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check("vld", vld, m_vis());
      if (m_vis()) check("dout", dout, mq[0].payload);
      check("credit_empty", credit_empty, m_pending == 0);
      check("credit_out", credit_out, m_credit());
`ifdef INPUT_PORT_OVERFLOW_CHECK_EN
      check("overflow", overflow, m_ovf);
`else
      check("overflow", overflow, 1'b0);
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin drive(1'b0, {$urandom, $urandom}); step(); end
   endtask

   task automatic do_reset();
      reset = 1'b0; drive(1'b0, 64'd0); step(); reset = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " vld"},          vld, 1'b0);
      check({tag, " dout"},         dout, 64'd0);
      check({tag, " credit_empty"}, credit_empty, 1'b1);
      check({tag, " credit_out"},   credit_out, {PKT{1'b0}});
      check({tag, " overflow"},     overflow, 1'b0);
   endtask

   // --------------------------------------------------------- vector table ----
   typedef struct {
      bit          in_v;
      logic [63:0] pl;
      bit          ack;
      bit          exp_vld;
      logic [63:0] exp_dout;
   } vec_t;
   vec_t vecs [10];

   initial begin
      vecs[0] = '{1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0, 64'h0};          // write, empty FIFO
      vecs[1] = '{1'b0, 64'h0,         1'b1, 1'b0, 64'h0};          // read register stage
      vecs[2] = '{1'b0, 64'h0,         1'b1, 1'b1, 64'hDEAD_BEEF};  // visible 2 edges on
      vecs[3] = '{1'b0, 64'h0,         1'b1, 1'b0, 64'h0};          // popped
      vecs[4] = '{1'b1, 64'h1111,      1'b1, 1'b0, 64'h0};          // ack without vld ignored
      vecs[5] = '{1'b1, 64'h2222,      1'b0, 1'b0, 64'h0};
      vecs[6] = '{1'b0, 64'h0,         1'b0, 1'b1, 64'h1111};
      vecs[7] = '{1'b0, 64'h0,         1'b0, 1'b1, 64'h1111};       // held while ack low
      vecs[8] = '{1'b0, 64'h0,         1'b1, 1'b1, 64'h2222};       // back-to-back pop
      vecs[9] = '{1'b0, 64'h0,         1'b1, 1'b0, 64'h0};

      n_checks = 0; n_pass = 0; cyc = 0; last_pop = -1000;
      m_pending = 0; m_consumed = 0; m_ovf = 0;
      m_leaf = '0; m_port = '0; m_faddr = '0;
      update_src_en = 1'b0; src_leaf = '0; src_port = '0; src_fifo_addr = '0;
      ack = 1'b0; credit_rd_en = 1'b0;
      drive(1'b0, 64'd0);

      // Reset held low for two cycles.
      reset = 1'b0;
      step(); step();
      check_reset_outputs("reset");
      reset = 1'b1;

      // Single-packet latency and handshake vectors.
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].in_v, vecs[i].pl);
         ack = vecs[i].ack;
         step();
         check($sformatf("vec%0d vld", i), vld, vecs[i].exp_vld);
         if (vecs[i].exp_vld) check($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
      end

      // Ten back-to-back packets. ack is low for the first five cycles.
      got.delete(); pop_steps.delete(); exp_list.delete();
      for (int i = 0; i < 10; i++) begin
         ack = (i >= 5);
         drive(1'b1, 64'hA000 + 64'(i));
         exp_list.push_back(64'hA000 + 64'(i));
         step();
      end
      ack = 1'b1;
      idle(15);
      check("b2b count", got.size(), 10);
      check("b2b order", mism(), 0);
      if (pop_steps.size() == 10) check("b2b one per cycle", pop_steps[9] - pop_steps[0], 9);

      // Credit generation: eight pops give two pending credits.
      do_reset();
      update_src_en = 1'b1; src_leaf = 6'd3; src_port = 4'd2; src_fifo_addr = 7'h15;
      idle(1);
      update_src_en = 1'b0;
      ack = 1'b1;
      for (int i = 0; i < 8; i++) begin drive(1'b1, 64'hC000 + 64'(i)); step(); end
      idle(6);
      ack = 1'b0;
      check("credit pending", credit_empty, 1'b0);
      check("credit vld bit", credit_out[96], 1'b1);
      check("credit leaf", credit_out[95:90], 6'd3);
      check("credit port", credit_out[89:86], 4'd2);
      check("credit payload", credit_out[63:0], 64'd4);
      update_src_en = 1'b1; src_leaf = 6'd9; src_port = 4'd5; src_fifo_addr = 7'h2A;
      idle(1);
      update_src_en = 1'b0;
      check("credit new leaf", credit_out[95:90], 6'd9);
      credit_rd_en = 1'b1;
      idle(1);
      check("credit after 1 take", credit_empty, 1'b0);
      idle(1);
      check("credit after 2 takes", credit_empty, 1'b1);
      credit_rd_en = 1'b0;

      // Fill to 128 entries; the 129th packet is dropped.
      do_reset();
      ack = 1'b0;
      got.delete(); exp_list.delete();
      for (int i = 0; i < 129; i++) begin
         drive(1'b1, 64'h1000 + 64'(i));
         if (i < 128) exp_list.push_back(64'h1000 + 64'(i));
         step();
      end
      idle(2);
`ifdef INPUT_PORT_OVERFLOW_CHECK_EN
      check("full overflow", overflow, 1'b1);
`else
      check("full overflow", overflow, 1'b0);
`endif
      ack = 1'b1;
      idle(135);
      check("full drain count", got.size(), 128);
      check("full drain data", mism(), 0);

      // Pop and write together at occupancy 127, then fill and overfill.
      do_reset();
      ack = 1'b0;
      got.delete(); exp_list.delete();
      for (int i = 0; i < 127; i++) begin
         drive(1'b1, 64'h2000 + 64'(i));
         exp_list.push_back(64'h2000 + 64'(i));
         step();
      end
      idle(2);
      ack = 1'b1; drive(1'b1, 64'h2FFF); exp_list.push_back(64'h2FFF); step();
      ack = 1'b0; drive(1'b1, 64'h3000); exp_list.push_back(64'h3000); step();
      drive(1'b1, 64'h3001); step();   // occupancy is 128 here: dropped
      ack = 1'b1;
      idle(140);
      check("occ127 drain count", got.size(), 129);
      check("occ127 drain data", mism(), 0);

      // Reset in the middle of a drain discards contents and credits.
      do_reset();
      for (int i = 0; i < 20; i++) begin drive(1'b1, 64'h5000 + 64'(i)); step(); end
      idle(2);
      ack = 1'b1;
      idle(5);
      reset = 1'b0; drive(1'b0, 64'd0); step();
      check_reset_outputs("mid-drain reset");
      reset = 1'b1;
      idle(4);
      check("post-reset empty", vld, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 2500; i++) begin
         bit heavy = ((i / 500) % 2) == 0;
         drive($urandom_range(0, 99) < (heavy ? 90 : 30), {$urandom, $urandom});
         ack           = $urandom_range(0, 99) < (heavy ? 20 : 80);
         credit_rd_en  = $urandom_range(0, 99) < 25;
         update_src_en = $urandom_range(0, 49) == 0;
         src_leaf      = 6'($urandom);
         src_port      = 4'($urandom);
         src_fifo_addr = 7'($urandom);
         reset         = !($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b1; update_src_en = 1'b0; credit_rd_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
